// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA channel arbiter: FSM state encoding,
// default parameter values and a packed-field extractor.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } dma_arb_state_e;

  localparam int DEF_N_CH = 4;
  localparam int DEF_AW   = 32;
  localparam int DEF_LW   = 16;
  localparam int DEF_TMO  = 1024;

  // Upper bounds for extract_field: up to 8 channels of up to 64-bit fields.
  localparam int FIELD_MAX_W = 64;
  localparam int FIELD_BUS_W = 8 * FIELD_MAX_W;

  // Returns bits [idx*w +: w] of a packed per-channel bus, zero-extended.
  function automatic logic [FIELD_MAX_W-1:0] extract_field(
    input logic [FIELD_BUS_W-1:0] bus_v,
    input int unsigned            idx,
    input int unsigned            w
  );
    logic [FIELD_MAX_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < FIELD_MAX_W; b++) begin
      if (b < w && (idx * w + b) < FIELD_BUS_W) r[b] = bus_v[idx * w + b];
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_chan_arb_if.sv
// Bundle of channel-side and engine-side signals around the DMA arbiter.
// Handshake: a channel holds ch_valid and its descriptor stable until the
// single-cycle ch_ready; ch_done/ch_err and eng_done/eng_err are one-cycle pulses.
interface dma_chan_arb_if #(
  parameter int N_CH = dma_arb_pkg::DEF_N_CH,
  parameter int AW   = dma_arb_pkg::DEF_AW,
  parameter int LW   = dma_arb_pkg::DEF_LW
) ();
  localparam int IW = $clog2(N_CH);

  logic [N_CH-1:0]    ch_valid;
  logic [N_CH-1:0]    ch_ready;
  logic [N_CH*AW-1:0] ch_src;
  logic [N_CH*AW-1:0] ch_dst;
  logic [N_CH*LW-1:0] ch_len;
  logic [N_CH-1:0]    ch_done;
  logic [N_CH-1:0]    ch_err;
  logic               eng_start;
  logic [AW-1:0]      eng_src;
  logic [AW-1:0]      eng_dst;
  logic [LW-1:0]      eng_len;
  logic               eng_abort;
  logic               eng_done;
  logic               eng_err;
  logic               busy;
  logic [IW-1:0]      cur_ch;
  dma_arb_pkg::dma_arb_state_e dbg_state;

  modport slave (
    input  ch_valid, ch_src, ch_dst, ch_len, eng_done, eng_err,
    output ch_ready, ch_done, ch_err, eng_start, eng_src, eng_dst, eng_len,
    output eng_abort, busy, cur_ch, dbg_state
  );

  modport master (
    output ch_valid, ch_src, ch_dst, ch_len, eng_done, eng_err,
    input  ch_ready, ch_done, ch_err, eng_start, eng_src, eng_dst, eng_len,
    input  eng_abort, busy, cur_ch, dbg_state
  );
endinterface

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1, wrapping modulo N_CH.
module dma_rr_pick #(
  parameter int N_CH = 4,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dma_chan_arb.sv
// Round-robin DMA channel scheduler: grants one descriptor at a time to the
// single engine, supervises it with a watchdog and reports per-channel done/error.
module dma_chan_arb
  import dma_arb_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int AW   = DEF_AW,
  parameter int LW   = DEF_LW,
  parameter int TMO  = DEF_TMO
) (
  input  logic           clk,
  input  logic           rst,
  dma_chan_arb_if.slave  bus
);

  localparam int IW  = $clog2(N_CH);
  localparam int WDW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TMO > 0) ? TMO - 1 : 0);

  dma_arb_state_e  state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   cur_ch_q, cur_ch_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [LW-1:0]   len_q, len_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [N_CH-1:0] ch_done_q, ch_done_d;
  logic [N_CH-1:0] ch_err_q, ch_err_d;
  logic            eng_start_q, eng_start_d;
  logic            eng_abort_q, eng_abort_d;

  logic [N_CH-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [LW-1:0]   new_len;

  dma_rr_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .req     (bus.ch_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign new_len = LW'(extract_field(FIELD_BUS_W'(bus.ch_len), int'(pick_idx), LW));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_ch_d    = cur_ch_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    wd_d        = wd_q;
    ch_done_d   = '0;
    ch_err_d    = '0;
    eng_start_d = 1'b0;
    eng_abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          cur_ch_d = pick_idx;
          src_d    = AW'(extract_field(FIELD_BUS_W'(bus.ch_src), int'(pick_idx), AW));
          dst_d    = AW'(extract_field(FIELD_BUS_W'(bus.ch_dst), int'(pick_idx), AW));
          len_d    = new_len;
          // Zero-length descriptors complete immediately without touching the engine.
          if (new_len != '0) begin
            state_d     = ST_ISSUE;
            eng_start_d = 1'b1;
          end else begin
            state_d             = ST_DONE;
            ch_done_d[pick_idx] = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (bus.eng_done) begin
          state_d             = ST_DONE;
          ch_done_d[cur_ch_q] = 1'b1;
          ch_err_d[cur_ch_q]  = bus.eng_err;
        end else if (TMO != 0 && wd_q == WD_LAST) begin
          state_d             = ST_DONE;
          eng_abort_d         = 1'b1;
          ch_done_d[cur_ch_q] = 1'b1;
          ch_err_d[cur_ch_q]  = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = cur_ch_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IW'(N_CH - 1);
      cur_ch_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      wd_q        <= '0;
      ch_done_q   <= '0;
      ch_err_q    <= '0;
      eng_start_q <= 1'b0;
      eng_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_ch_q    <= cur_ch_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      wd_q        <= wd_d;
      ch_done_q   <= ch_done_d;
      ch_err_q    <= ch_err_d;
      eng_start_q <= eng_start_d;
      eng_abort_q <= eng_abort_d;
    end
  end

  // ch_ready is combinational; it is masked during reset so every strobe reads 0.
  assign bus.ch_ready  = (state_q == ST_IDLE && !rst) ? pick_gnt : '0;
  assign bus.ch_done   = ch_done_q;
  assign bus.ch_err    = ch_err_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_abort = eng_abort_q;
  assign bus.eng_src   = src_q;
  assign bus.eng_dst   = dst_q;
  assign bus.eng_len   = len_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cur_ch    = cur_ch_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dma_chan_arb.sv
// Directed bench for dma_chan_arb (N_CH=4, TMO=16) with hand-computed expectations.
module tb_dma_chan_arb;
  import dma_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [1:0] exp_q[$];

  dma_chan_arb_if #(.N_CH(4), .AW(32), .LW(16)) bus ();

  dma_chan_arb #(.N_CH(4), .AW(32), .LW(16), .TMO(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int ch, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l);
    bus.ch_src[ch*32 +: 32] = s;
    bus.ch_dst[ch*32 +: 32] = d;
    bus.ch_len[ch*16 +: 16] = l;
  endtask

  // Grant ch0 (len 4) and let the engine stay silent until the watchdog cycle;
  // optionally return eng_done exactly in that expiry cycle.
  task automatic run_wd(input logic collide);
    next_cycle();
    set_desc(0, 32'hA000, 32'hB000, 16'd4);
    bus.ch_valid = 4'b0001;
    @(negedge clk);
    check("wd_ready", 64'(bus.ch_ready), 64'h1);
    next_cycle();
    bus.ch_valid = 4'b0000;
    @(negedge clk);
    check("wd_start", 64'(bus.eng_start), 64'h1);
    repeat (16) next_cycle();
    if (collide) begin
      bus.eng_done = 1'b1;
      bus.eng_err  = 1'b0;
    end
    @(negedge clk);
    check("wd_last_wait_state", 64'(bus.dbg_state), 64'(ST_WAIT));
    check("wd_no_early_abort", 64'(bus.eng_abort), 64'h0);
    next_cycle();
    bus.eng_done = 1'b0;
    @(negedge clk);
    check(collide ? "coll_abort" : "wd_abort", 64'(bus.eng_abort), collide ? 64'h0 : 64'h1);
    check("wd_done", 64'(bus.ch_done), 64'h1);
    check(collide ? "coll_err" : "wd_err", 64'(bus.ch_err), collide ? 64'h0 : 64'h1);
    next_cycle();
    @(negedge clk);
    check("wd_abort_clear", 64'(bus.eng_abort), 64'h0);
    check("wd_idle", 64'(bus.busy), 64'h0);
  endtask

  initial begin
    logic [1:0] exp_ch;
    rst          = 1'b1;
    bus.ch_valid = '0;
    bus.ch_src   = '0;
    bus.ch_dst   = '0;
    bus.ch_len   = '0;
    bus.eng_done = 1'b0;
    bus.eng_err  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(bus.ch_ready), 64'h0);
    check("rst_done", 64'(bus.ch_done), 64'h0);
    check("rst_start", 64'(bus.eng_start), 64'h0);
    check("rst_abort", 64'(bus.eng_abort), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_cur_ch", 64'(bus.cur_ch), 64'h0);
    check("rst_eng_src", 64'(bus.eng_src), 64'h0);
    check("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    next_cycle();
    rst = 1'b0;

    // Round-robin fairness: all four channels held valid, engine answers at once
    for (int i = 0; i < 4; i++) set_desc(i, 32'h100 * (i + 1), 32'h800 + i, 16'(i + 1));
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int g = 0; g < 5; g++) begin
      next_cycle();
      if (g == 0) bus.ch_valid = 4'b1111;
      exp_ch = exp_q.pop_front();
      @(negedge clk);
      check("rr_ready", 64'(bus.ch_ready), 64'(4'b0001 << exp_ch));
      next_cycle();
      @(negedge clk);
      check("rr_start", 64'(bus.eng_start), 64'h1);
      check("rr_cur_ch", 64'(bus.cur_ch), 64'(exp_ch));
      check("rr_len", 64'(bus.eng_len), 64'(exp_ch) + 64'h1);
      next_cycle();
      bus.eng_done = 1'b1;
      @(negedge clk);
      check("rr_no_ready_busy", 64'(bus.ch_ready), 64'h0);
      next_cycle();
      bus.eng_done = 1'b0;
      @(negedge clk);
      check("rr_done", 64'(bus.ch_done), 64'(4'b0001 << exp_ch));
    end
    bus.ch_valid = 4'b0000;
    check("rr_queue_empty", 64'(exp_q.size()), 64'h0);

    // Single request on ch2
    next_cycle();
    set_desc(2, 32'h1000, 32'h2000, 16'd8);
    bus.ch_valid = 4'b0100;
    @(negedge clk);
    check("one_ready", 64'(bus.ch_ready), 64'h4);
    next_cycle();
    bus.ch_valid = 4'b0000;
    @(negedge clk);
    check("one_start", 64'(bus.eng_start), 64'h1);
    check("one_src", 64'(bus.eng_src), 64'h1000);
    check("one_dst", 64'(bus.eng_dst), 64'h2000);
    check("one_len", 64'(bus.eng_len), 64'h8);
    check("one_cur_ch", 64'(bus.cur_ch), 64'h2);
    check("one_busy", 64'(bus.busy), 64'h1);
    next_cycle();
    @(negedge clk);
    check("one_start_pulse", 64'(bus.eng_start), 64'h0);
    repeat (3) next_cycle();
    bus.eng_done = 1'b1;
    @(negedge clk);
    check("one_done_not_yet", 64'(bus.ch_done), 64'h0);
    next_cycle();
    bus.eng_done = 1'b0;
    @(negedge clk);
    check("one_done", 64'(bus.ch_done), 64'h4);
    check("one_err", 64'(bus.ch_err), 64'h0);
    // Stray eng_done while idle must be ignored
    next_cycle();
    bus.eng_done = 1'b1;
    @(negedge clk);
    check("stray_idle", 64'(bus.busy), 64'h0);
    next_cycle();
    bus.eng_done = 1'b0;
    @(negedge clk);
    check("stray_no_done", 64'(bus.ch_done), 64'h0);
    check("stray_still_idle", 64'(bus.busy), 64'h0);

    // Zero-length request on ch1
    next_cycle();
    set_desc(1, 32'h3000, 32'h4000, 16'd0);
    bus.ch_valid = 4'b0010;
    @(negedge clk);
    check("zl_ready", 64'(bus.ch_ready), 64'h2);
    next_cycle();
    bus.ch_valid = 4'b0000;
    @(negedge clk);
    check("zl_done", 64'(bus.ch_done), 64'h2);
    check("zl_err", 64'(bus.ch_err), 64'h0);
    check("zl_no_start", 64'(bus.eng_start), 64'h0);
    next_cycle();
    @(negedge clk);
    check("zl_no_start_after", 64'(bus.eng_start), 64'h0);
    check("zl_idle", 64'(bus.busy), 64'h0);

    // Watchdog expiry, then eng_done colliding with expiry
    run_wd(1'b0);
    run_wd(1'b1);

    // Engine error on ch3
    next_cycle();
    set_desc(3, 32'h5000, 32'h6000, 16'd2);
    bus.ch_valid = 4'b1000;
    @(negedge clk);
    check("err_ready", 64'(bus.ch_ready), 64'h8);
    next_cycle();
    bus.ch_valid = 4'b0000;
    next_cycle();
    bus.eng_done = 1'b1;
    bus.eng_err  = 1'b1;
    next_cycle();
    bus.eng_done = 1'b0;
    bus.eng_err  = 1'b0;
    @(negedge clk);
    check("err_done", 64'(bus.ch_done), 64'h8);
    check("err_flag", 64'(bus.ch_err), 64'h8);
    check("err_no_abort", 64'(bus.eng_abort), 64'h0);

    // Reset while waiting on the engine
    next_cycle();
    set_desc(2, 32'h7000, 32'h7800, 16'd5);
    bus.ch_valid = 4'b0100;
    @(negedge clk);
    check("rw_ready", 64'(bus.ch_ready), 64'h4);
    next_cycle();
    bus.ch_valid = 4'b0101;
    next_cycle();
    rst = 1'b1;
    #1;
    check("rw_busy", 64'(bus.busy), 64'h0);
    check("rw_cur_ch", 64'(bus.cur_ch), 64'h0);
    check("rw_src", 64'(bus.eng_src), 64'h0);
    check("rw_len", 64'(bus.eng_len), 64'h0);
    check("rw_ready_masked", 64'(bus.ch_ready), 64'h0);
    check("rw_no_abort", 64'(bus.eng_abort), 64'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rw_first_grant", 64'(bus.ch_ready), 64'h1);
    next_cycle();
    bus.ch_valid = 4'b0000;
    @(negedge clk);
    check("rw_cur_ch0", 64'(bus.cur_ch), 64'h0);
    check("rw_src0", 64'(bus.eng_src), 64'hA000);
    next_cycle();
    bus.eng_done = 1'b1;
    next_cycle();
    bus.eng_done = 1'b0;
    @(negedge clk);
    check("rw_done0", 64'(bus.ch_done), 64'h1);

    // Final report
    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
